// File: rtl/rv_isa_pkg.sv
// Shared RISC-V ISA constants, instruction-class enum and encoder FIFO entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Used by the instruction encoder and the control-path opcode decoder.
package rv_isa_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        CLS_R      = 2'b00,
        CLS_LOAD   = 2'b01,
        CLS_STORE  = 2'b10,
        CLS_BRANCH = 2'b11
    } rv_class_e;

    // The address is carried at full 32 bits so the entry type does not depend
    // on the encoder's ADDR_W; the top zero-extends on push and truncates on pop.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } enc_entry_t;

endpackage

// File: rtl/rv_instr_encoder_if.sv
// Field-in / word-out handshake bundle of the instruction encoder.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready carried here; slave = encoder, master = producer/consumer.
// Signals: flush, in_valid/in_ready/in_class/in_rd/in_rs1/in_rs2/in_funct3/in_funct7/in_imm,
//          out_valid/out_ready/out_instr/out_addr/out_err.
interface rv_instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_class;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [12:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport slave (
        input  flush, in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport master (
        output flush, in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/enc_fifo2.sv
// Generic two-entry valid/ready buffer with synchronous flush.
// Latency: push in cycle N is visible at the head in cycle N+1 when empty.
// Backpressure: push_rdy = !FULL from registered state only; no path from pop_rdy.
// Ports: clk, rst_n, flush, push_vld/push_rdy/push_dat, pop_vld/pop_rdy/pop_dat.
module enc_fifo2 #(
    parameter type T       = logic [7:0],
    parameter T    RST_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic push_vld,
    output logic push_rdy,
    input  T     push_dat,
    output logic pop_vld,
    input  logic pop_rdy,
    output T     pop_dat
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_st_e;

    fifo_st_e st;
    T         head;
    T         tail;
    logic     push;
    logic     pop;

    assign push_rdy = (st != ST_FULL);
    assign pop_vld  = (st != ST_EMPTY);
    assign pop_dat  = head;
    assign push     = push_vld && push_rdy;
    assign pop      = pop_vld && pop_rdy;

    // The head only changes on a pop or on a push into an empty slot, so the
    // output stays stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= ST_EMPTY;
            head <= RST_VAL;
            tail <= RST_VAL;
        end else if (flush) begin
            st <= ST_EMPTY;
        end else begin
            case (st)
                ST_EMPTY: begin
                    if (push) begin
                        head <= push_dat;
                        st   <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head <= push_dat;
                    end else if (push) begin
                        tail <= push_dat;
                        st   <= ST_FULL;
                    end else if (pop) begin
                        st <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head <= tail;
                        st   <= ST_ONE;
                    end
                end
                default: st <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// RISC-V R/LOAD/STORE/BRANCH field encoder with sequential byte addressing and a 2-word buffer.
// Latency: accept in cycle N -> out_valid in cycle N+1 when the buffer was empty; 1 word/cycle.
// Backpressure: in_ready = buffer not full (registered); outputs held while out_valid && !out_ready.
// Ports: clk, rst_n, bus (rv_instr_encoder_if.slave).
// Option: RV_ENC_RANGE_CHECK_EN enables out_err for non-encodable immediates.
module rv_instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    rv_instr_encoder_if.slave  bus
);

    localparam enc_entry_t ENTRY_RST = '{instr: 32'd0, addr: 32'(BASE_ADDR), err: 1'b0};

    rv_class_e   cls;
    logic [31:0] word;
    logic        err;
    logic        push;
    logic [ADDR_W-1:0] ptr;
    enc_entry_t  push_dat;
    enc_entry_t  head;

    assign cls = rv_class_e'(bus.in_class);

    always_comb begin
        word = 32'd0;
        case (cls)
            CLS_R:      word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                bus.in_rd, OPC_R};
            CLS_LOAD:   word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                                bus.in_rd, OPC_LOAD};
            CLS_STORE:  word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                bus.in_imm[4:0], OPC_STORE};
            CLS_BRANCH: word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                                bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], OPC_BRANCH};
            default:    word = 32'd0;
        endcase
    end

`ifdef RV_ENC_RANGE_CHECK_EN
    // LOAD/STORE carry 12 bits, so bit 12 must be a copy of the sign bit 11;
    // BRANCH offsets are 2-byte aligned, so bit 0 cannot be represented.
    always_comb begin
        err = 1'b0;
        case (cls)
            CLS_LOAD, CLS_STORE: err = (bus.in_imm[12] != bus.in_imm[11]);
            CLS_BRANCH:          err = bus.in_imm[0];
            default:             err = 1'b0;
        endcase
    end
`else
    assign err = 1'b0;
`endif

    assign push     = bus.in_valid && bus.in_ready;
    assign push_dat = '{instr: word, addr: 32'(ptr), err: err};

    // A push that coincides with flush is dropped, so the pointer must not move either.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= BASE_ADDR;
        end else if (bus.flush) begin
            ptr <= BASE_ADDR;
        end else if (push) begin
            ptr <= ptr + ADDR_W'(4);
        end
    end

    enc_fifo2 #(
        .T       (enc_entry_t),
        .RST_VAL (ENTRY_RST)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.flush),
        .push_vld (bus.in_valid),
        .push_rdy (bus.in_ready),
        .push_dat (push_dat),
        .pop_vld  (bus.out_valid),
        .pop_rdy  (bus.out_ready),
        .pop_dat  (head)
    );

    assign bus.out_instr = head.instr;
    assign bus.out_addr  = head.addr[ADDR_W-1:0];
    assign bus.out_err   = head.err;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder with hand-computed encodings.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low while offering words.
module tb_rv_instr_encoder;
    import rv_isa_pkg::*;

    localparam int ADDR_W = 10;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    logic exp_err;

    rv_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    rv_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [1:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [12:0] imm);
        bus.in_class  = cls;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
    endtask

    // Inputs change 1 time unit after a rising edge; in_ready is registered so it is
    // stable for the rest of the cycle.
    task automatic offer(input logic [1:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [12:0] imm);
        int waited;
        set_fields(cls, rd, rs1, rs2, f3, f7, imm);
        bus.in_valid = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) chk("offer_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] instr, input logic [ADDR_W-1:0] addr,
                           input logic err);
        chk({tag, "_vld"},   64'(bus.out_valid), 64'd1);
        chk({tag, "_instr"}, 64'(bus.out_instr), 64'(instr));
        chk({tag, "_addr"},  64'(bus.out_addr),  64'(addr));
        chk({tag, "_err"},   64'(bus.out_err),   64'(err));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
`ifdef RV_ENC_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_fields(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
        chk("rst_out_addr",  64'(bus.out_addr),  64'd0);
        chk("rst_out_err",   64'(bus.out_err),   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // R-type, visible the cycle after accept
        offer(2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
        chk("r_latency", 64'(bus.out_valid), 64'd1);
        pop_chk("r", 32'h002081B3, 10'd0, 1'b0);
        chk("r_empty", 64'(bus.out_valid), 64'd0);

        // LOAD then STORE from a fresh pointer
        do_flush();
        offer(2'b01, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 13'd8);
        offer(2'b10, 5'd0, 5'd2, 5'd6, 3'b010, 7'd0, 13'h1FFC);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        pop_chk("load",  32'h00812283, 10'd0, 1'b0);
        pop_chk("store", 32'hFE612E23, 10'd4, 1'b0);

        // BRANCH continues the address sequence
        offer(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8);
        pop_chk("branch", 32'hFE208CE3, 10'd8, 1'b0);

        // Backpressure: third word waits, then drains in order
        do_flush();
        offer(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
        offer(2'b00, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
        set_fields(2'b00, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
        bus.in_valid = 1'b1;
        chk("bp_rdy0", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp_rdy1",  64'(bus.in_ready),  64'd0);
        chk("bp_hold_i", 64'(bus.out_instr), 64'h000000B3);
        chk("bp_hold_a", 64'(bus.out_addr),  64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_w1_i", 64'(bus.out_instr), 64'h00000133);
        chk("bp_w1_a", 64'(bus.out_addr),  64'd4);
        chk("bp_w1_rdy", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_w2_v", 64'(bus.out_valid), 64'd1);
        chk("bp_w2_i", 64'(bus.out_instr), 64'h000001B3);
        chk("bp_w2_a", 64'(bus.out_addr),  64'd8);
        @(posedge clk); #1;
        chk("bp_drained", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // Range check (err expectation depends on build option)
        do_flush();
        offer(2'b01, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd2048);
        pop_chk("ld2048", 32'h80000003, 10'd0, exp_err);
        offer(2'b11, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5);
        pop_chk("br5", 32'h00000263, 10'd4, exp_err);

        // Flush in FULL with a concurrent offer: nothing survives, pointer rewinds
        offer(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
        offer(2'b00, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_vld", 64'(bus.out_valid), 64'd0);
        chk("flush_rdy", 64'(bus.in_ready),  64'd1);
        offer(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
        pop_chk("post_flush", 32'h000000B3, 10'd0, 1'b0);

        // Asynchronous reset mid-stream
        offer(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8);
        offer(2'b00, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld",   64'(bus.out_valid), 64'd0);
        chk("arst_instr", 64'(bus.out_instr), 64'd0);
        chk("arst_addr",  64'(bus.out_addr),  64'd0);
        chk("arst_rdy",   64'(bus.in_ready),  64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
